// File: rtl/segment_pattern_decoder.sv
// Seven-segment scan decoder: debounces each scanned digit position and
// hands complete frames downstream over a valid/ready handshake.
module segment_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 6
) (
  input  logic                    clock_50Mhz,
  input  logic                    reset,
  input  logic [6:0]              segments_in,
  input  logic [2:0]              digit_sel,
  input  logic                    sample_en,
  input  logic                    frame_done,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_error_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam logic [3:0] SAT = 4'(STABLE_CYCLES);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t                  state;
  logic [6:0]              last_pattern;
  logic [2:0]              last_sel;
  logic [3:0]              cnt;
  logic [3:0]              cnt_nxt;
  logic                    match;
  logic                    in_range;
  logic                    wr_en;
  logic [3:0]              dec_code;
  logic                    dec_err;
  logic [4*NUM_DIGITS-1:0] slot_code;
  logic [NUM_DIGITS-1:0]   slot_err;

  // Patterns are active-low, listed g..a
  always_comb begin
    dec_code = 4'd15;
    unique case (segments_in)
      7'b1000000: dec_code = 4'd0;
      7'b1111001: dec_code = 4'd1;
      7'b0100100: dec_code = 4'd2;
      7'b0110000: dec_code = 4'd3;
      7'b0011001: dec_code = 4'd4;
      7'b0010010: dec_code = 4'd5;
      7'b0000010: dec_code = 4'd6;
      7'b1111000: dec_code = 4'd7;
      7'b0000000: dec_code = 4'd8;
      7'b0011000: dec_code = 4'd9;
      7'b1111111: dec_code = 4'd10;
      default:    dec_code = 4'd15;
    endcase
    dec_err = (dec_code == 4'd15);
  end

  always_comb begin
    match    = (segments_in == last_pattern) &&
               (digit_sel == last_sel);
    in_range = ({29'd0, digit_sel} < NUM_DIGITS);
    cnt_nxt  = 4'd1;
    if (match) begin
      cnt_nxt = (cnt == SAT) ? cnt : cnt + 4'd1;
    end
    // One write per stable run; a depth of one rewrites every sample
    wr_en = sample_en && in_range &&
            (cnt_nxt == SAT) &&
            ((SAT == 4'd1) || !match || (cnt != SAT));
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      last_pattern <= 7'b1111111;
      last_sel     <= 3'd0;
      cnt          <= 4'd0;
      slot_code    <= {NUM_DIGITS{4'd10}};
      slot_err     <= '0;
    end else if (sample_en) begin
      last_pattern <= segments_in;
      last_sel     <= digit_sel;
      cnt          <= cnt_nxt;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en && (digit_sel == 3'(i))) begin
          slot_code[4*i +: 4] <= dec_code;
          slot_err[i]         <= dec_err;
        end
      end
    end
  end

  // Frame copy sees pre-write slots, so a same-edge write lands next frame
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state          <= EMPTY;
      out_valid      <= 1'b0;
      overrun        <= 1'b0;
      out_digits     <= {NUM_DIGITS{4'd10}};
      out_error_mask <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (frame_done) begin
            out_digits     <= slot_code;
            out_error_mask <= slot_err;
            out_valid      <= 1'b1;
            state          <= FULL;
          end
        end
        FULL: begin
          if (frame_done && out_ready) begin
            out_digits     <= slot_code;
            out_error_mask <= slot_err;
          end else if (frame_done) begin
            overrun <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/segment_pattern_decoder.md
SEGMENT_PATTERN_DECODER -- requirements
Module: segment_pattern_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is accepted; legal range 1..15.
REQ-002 The block SHALL have parameter NUM_DIGITS, default 6: number of scanned digit positions; legal range 1..8.
REQ-003 The block SHALL have port clock_50Mhz, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port segments_in, input, 7 bits: active-low segment lines, bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-006 The block SHALL have port digit_sel, input, 3 bits: index of the digit position currently presented on segments_in.
REQ-007 The block SHALL have port sample_en, input, 1 bit: qualifies segments_in and digit_sel in this cycle.
REQ-008 The block SHALL have port frame_done, input, 1 bit: single-cycle pulse marking the end of one full scan of all positions.
REQ-009 The block SHALL have port out_digits, output, 4*NUM_DIGITS bits: decoded codes, position i at bits [4i+3:4i].
REQ-010 The block SHALL have port out_error_mask, output, NUM_DIGITS bits: bit i set when position i held an illegal pattern.
REQ-011 The block SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit): valid/ready handshake for one frame.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag set when a frame is dropped.

Function
REQ-013 Decode table (pattern g..a -> code) SHALL be exactly:
- 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
- 0011000->9, 0010010->5, 0000010->6, 1111000->7, 0000000->8
- 1111111->10 (blank)
- any other pattern->15, with the error bit set.
REQ-014 Stability filter SHALL hold last_pattern, last_sel, and a saturating counter; it updates only on sample_en=1.
REQ-015 On sample_en=1 with {segments_in,digit_sel} equal to {last_pattern,last_sel}, the counter SHALL increment, saturating at STABLE_CYCLES.
REQ-016 On sample_en=1 with {segments_in,digit_sel} differing from {last_pattern,last_sel}, the block SHALL store the new values and set the counter to 1.
REQ-017 When the counter transitions to STABLE_CYCLES, the block SHALL write capture slot digit_sel (code plus error bit) on that same clock edge; it writes once per stable run, with no rewrite while saturated.
REQ-018 With STABLE_CYCLES=1, every sample_en cycle SHALL write its slot.
REQ-019 Samples with digit_sel >= NUM_DIGITS SHALL update the filter but never write a slot.
REQ-020 Capture slots SHALL persist across frames; a slot not refreshed in a frame reports its previous value.
REQ-021 The output FSM SHALL have states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-022 In EMPTY, frame_done=1 SHALL copy all slots to out_digits/out_error_mask and enter FULL; out_valid is high the next cycle.
REQ-023 In FULL, out_ready=1 without frame_done SHALL return the FSM to EMPTY.
REQ-024 In FULL, out_ready=1 with frame_done=1 SHALL load the new frame and remain in FULL.
REQ-025 In FULL, out_ready=0 with frame_done=1 SHALL drop the new frame, keep the outputs unchanged, and set overrun; overrun clears only on reset.
REQ-026 out_digits and out_error_mask SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 A slot write and a frame_done in the same cycle SHALL copy the pre-write slot value into the frame; the new value appears in the next frame.

Reset
REQ-028 On a clock edge with reset=1, the block SHALL load all slots with code 10 and error 0, set out_digits to all 10, clear out_error_mask, clear out_valid and overrun, clear the counter, set last_pattern=1111111 and last_sel=0, and enter EMPTY.
REQ-029 Reset SHALL override all other inputs in the same cycle, including mid-frame and during FULL; a pending frame is discarded.

Verification
REQ-030 The bench SHALL cover: STABLE_CYCLES=4, sel=2, four sample_en cycles of 0100100, then a frame_done pulse -> one cycle later out_valid=1, digit2=2, all others 10, error mask 0.
REQ-031 The bench SHALL cover: three samples of 0110000 at sel=0, then one of 1111001 at sel=0, then frame_done -> digit0=10 (never stable).
REQ-032 The bench SHALL cover: four samples of 0101010 at sel=5, then frame_done -> digit5=15, out_error_mask=100000.
REQ-033 The bench SHALL cover: while FULL with out_ready=0, a frame_done pulse -> overrun=1 and outputs unchanged; then out_ready=1 -> out_valid=0 on the next cycle.
REQ-034 The bench SHALL cover: while FULL, out_ready=1 and frame_done in the same cycle -> out_valid stays 1, the new frame is loaded, and overrun stays 0.
REQ-035 The bench SHALL cover: reset asserted for one cycle while FULL with the counter at 3 -> next cycle out_valid=0, all digits 10, overrun=0, and a following sample restarts the count at 1.
